// File: rtl/sblk_act_feed.sv
// Activation feeder: turns one-cycle batch requests into cfg_len-word bursts pulled
// from a valid/ready source, with a two-deep request queue and a sticky overflow flag.
module sblk_act_feed #(
   parameter int WID_ACT = 8,
   parameter int WID_LEN = 8
) (
   input  logic                   clk_l,
   input  logic                   rst_n,
   input  logic                   cfg_en,
   input  logic [WID_LEN-1:0]     cfg_len,
   input  logic                   act_in_req,
   input  logic [2*WID_ACT-1:0]   src_data,
   input  logic                   src_vld,
   output logic                   src_rdy,
   output logic [2*WID_ACT-1:0]   act_in,
   output logic                   act_in_vld,
   output logic                   batch_done,
   output logic                   busy,
   output logic                   err_ovf
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t               state_q, state_d;
   logic [WID_LEN-1:0]   len_q, len_d;
   logic [WID_LEN-1:0]   cnt_q, cnt_d;
   logic [1:0]           pend_q, pend_d;
   logic [2*WID_ACT-1:0] act_in_q, act_in_d;
   logic                 act_in_vld_q, act_in_vld_d;
   logic                 batch_done_q, batch_done_d;
   logic                 err_ovf_q, err_ovf_d;

   logic                 acc, last, want, start;
   logic [WID_LEN-1:0]   len_m1;

   always_comb begin
      len_m1 = len_q - WID_LEN'(1);
      acc    = src_vld & (state_q == STREAM);
      last   = acc & (cnt_q == len_m1);
      want   = (pend_q != 2'd0) | act_in_req;
      // A new batch may begin from IDLE or on the last word of the current one (no bubble).
      start  = want & (len_q != '0) & ((state_q == IDLE) | last);

      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      err_ovf_d    = err_ovf_q;
      act_in_d     = acc ? src_data : act_in_q;
      act_in_vld_d = acc;
      batch_done_d = last & ~cfg_en;

      if (cfg_en) begin
         len_d     = cfg_len;
         pend_d    = 2'd0;
         cnt_d     = '0;
         err_ovf_d = 1'b0;
         state_d   = IDLE;
      end else begin
         if (start)     state_d = STREAM;
         else if (last) state_d = IDLE;

         if (last)      cnt_d = '0;
         else if (acc)  cnt_d = cnt_q + WID_LEN'(1);

         // Full queue with no start to drain it: drop the request and flag it.
         if ((pend_q == 2'd2) & act_in_req & ~start)
            err_ovf_d = 1'b1;
         else
            pend_d = pend_q + {1'b0, act_in_req} - {1'b0, start};
      end
   end

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         pend_q       <= 2'd0;
         act_in_q     <= '0;
         act_in_vld_q <= 1'b0;
         batch_done_q <= 1'b0;
         err_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         act_in_q     <= act_in_d;
         act_in_vld_q <= act_in_vld_d;
         batch_done_q <= batch_done_d;
         err_ovf_q    <= err_ovf_d;
      end
   end

   assign src_rdy    = (state_q == STREAM);
   assign busy       = (state_q == STREAM) | (pend_q != 2'd0);
   assign act_in     = act_in_q;
   assign act_in_vld = act_in_vld_q;
   assign batch_done = batch_done_q;
   assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_sblk_act_feed.sv
// Directed bench for sblk_act_feed: single batch, back-to-back, stalls, overflow,
// abort/disable and asynchronous reset mid-batch.
module tb_sblk_act_feed;

   logic        clk_l = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_en = 1'b0;
   logic [7:0]  cfg_len = 8'd0;
   logic        act_in_req = 1'b0;
   logic [15:0] src_data = 16'd0;
   logic        src_vld = 1'b0;
   logic        src_rdy, act_in_vld, batch_done, busy, err_ovf;
   logic [15:0] act_in;

   int total = 0;
   int bad   = 0;

   sblk_act_feed #(.WID_ACT(8), .WID_LEN(8)) dut (
      .clk_l(clk_l), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_len(cfg_len),
      .act_in_req(act_in_req), .src_data(src_data), .src_vld(src_vld),
      .src_rdy(src_rdy), .act_in(act_in), .act_in_vld(act_in_vld),
      .batch_done(batch_done), .busy(busy), .err_ovf(err_ovf)
   );

   always #5 clk_l = ~clk_l;

   task automatic tick();
      @(posedge clk_l);
      #1;
   endtask

   task automatic do_cfg(input logic [7:0] len);
      cfg_en = 1'b1; cfg_len = len;
      tick();
      cfg_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      total++; if ({src_rdy, act_in_vld, batch_done, busy, err_ovf} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%05b exp=00000", {src_rdy, act_in_vld, batch_done, busy, err_ovf});
      end
      total++; if (act_in !== 16'h0) begin
         bad++; $display("FAIL reset_act_in got=%h exp=0000", act_in);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_cfg(8'd8);
      src_vld = 1'b1; src_data = 16'hEEEE; act_in_req = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         act_in_req = 1'b0;
         total++; if (src_rdy !== (i <= 8)) begin
            bad++; $display("FAIL single_rdy t+%0d got=%b exp=%b", i, src_rdy, (i <= 8));
         end
         total++; if (act_in_vld !== (i >= 2 && i <= 9)) begin
            bad++; $display("FAIL single_vld t+%0d got=%b exp=%b", i, act_in_vld, (i >= 2 && i <= 9));
         end
         if (i >= 2 && i <= 9) begin
            total++; if (act_in !== 16'hA500 + 16'(i - 2)) begin
               bad++; $display("FAIL single_data t+%0d got=%h exp=%h", i, act_in, 16'hA500 + 16'(i - 2));
            end
         end
         total++; if (batch_done !== (i == 9)) begin
            bad++; $display("FAIL single_done t+%0d got=%b exp=%b", i, batch_done, (i == 9));
         end
         total++; if (busy !== (i <= 8)) begin
            bad++; $display("FAIL single_busy t+%0d got=%b exp=%b", i, busy, (i <= 8));
         end
         src_data = 16'hA500 + 16'(i - 1);
      end
      src_vld = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      do_cfg(8'd4);
      src_vld = 1'b1; src_data = 16'hEEEE; act_in_req = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         act_in_req = (i == 1);
         total++; if (src_rdy !== (i <= 8)) begin
            bad++; $display("FAIL b2b_rdy t+%0d got=%b exp=%b", i, src_rdy, (i <= 8));
         end
         total++; if (act_in_vld !== (i >= 2 && i <= 9)) begin
            bad++; $display("FAIL b2b_vld t+%0d got=%b exp=%b", i, act_in_vld, (i >= 2 && i <= 9));
         end
         if (i >= 2 && i <= 9) begin
            total++; if (act_in !== 16'hB600 + 16'(i - 2)) begin
               bad++; $display("FAIL b2b_data t+%0d got=%h exp=%h", i, act_in, 16'hB600 + 16'(i - 2));
            end
         end
         total++; if (batch_done !== (i == 5 || i == 9)) begin
            bad++; $display("FAIL b2b_done t+%0d got=%b exp=%b", i, batch_done, (i == 5 || i == 9));
         end
         src_data = 16'hB600 + 16'(i - 1);
      end
      src_vld = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      logic [15:0] last_data;
      logic        exp_vld;
      last_data = 16'h0;
      do_cfg(8'd6);
      src_vld = 1'b0; src_data = 16'hDEAD; act_in_req = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         act_in_req = 1'b0;
         exp_vld = (i % 2 == 0) && i >= 2 && i <= 12;
         total++; if (src_rdy !== (i <= 11)) begin
            bad++; $display("FAIL stall_rdy t+%0d got=%b exp=%b", i, src_rdy, (i <= 11));
         end
         total++; if (act_in_vld !== exp_vld) begin
            bad++; $display("FAIL stall_vld t+%0d got=%b exp=%b", i, act_in_vld, exp_vld);
         end
         if (exp_vld) begin
            last_data = 16'hC700 + 16'((i - 2) / 2);
            total++; if (act_in !== last_data) begin
               bad++; $display("FAIL stall_data t+%0d got=%h exp=%h", i, act_in, last_data);
            end
         end else if (i >= 3) begin
            total++; if (act_in !== last_data) begin
               bad++; $display("FAIL stall_hold t+%0d got=%h exp=%h", i, act_in, last_data);
            end
         end
         total++; if (batch_done !== (i == 12)) begin
            bad++; $display("FAIL stall_done t+%0d got=%b exp=%b", i, batch_done, (i == 12));
         end
         src_vld  = (i % 2 == 1);
         src_data = src_vld ? 16'hC700 + 16'((i - 1) / 2) : 16'hDEAD;
      end
      src_vld = 1'b0;
      tick();
   endtask

   // One request starts the batch, two more fill the queue, the fourth is dropped.
   task automatic test_overflow();
      do_cfg(8'd16);
      src_vld = 1'b0; act_in_req = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         act_in_req = (i == 2 || i == 4 || i == 6);
         total++; if (err_ovf !== (i >= 7)) begin
            bad++; $display("FAIL ovf_err t+%0d got=%b exp=%b", i, err_ovf, (i >= 7));
         end
         total++; if (busy !== 1'b1) begin
            bad++; $display("FAIL ovf_busy t+%0d got=%b exp=1", i, busy);
         end
      end
   endtask

   task automatic test_abort();
      do_cfg(8'd0);
      total++; if ({src_rdy, busy, err_ovf} !== 3'b000) begin
         bad++; $display("FAIL abort_clear got=%03b exp=000", {src_rdy, busy, err_ovf});
      end
      act_in_req = 1'b1; src_vld = 1'b1; src_data = 16'h1234;
      tick();
      act_in_req = 1'b0;
      total++; if (busy !== 1'b1) begin
         bad++; $display("FAIL abort_busy got=%b exp=1", busy);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if ({src_rdy, act_in_vld, busy} !== 3'b001) begin
            bad++; $display("FAIL abort_idle c%0d got=%03b exp=001", i, {src_rdy, act_in_vld, busy});
         end
      end
      // Disabled length still queues: pend 1 -> 2, then the next request overflows.
      act_in_req = 1'b1;
      tick();
      total++; if (err_ovf !== 1'b0) begin
         bad++; $display("FAIL dis_err_early got=%b exp=0", err_ovf);
      end
      tick();
      act_in_req = 1'b0;
      total++; if (err_ovf !== 1'b1) begin
         bad++; $display("FAIL dis_err_set got=%b exp=1", err_ovf);
      end
      src_vld = 1'b0;
      do_cfg(8'd0);
      total++; if ({busy, err_ovf} !== 2'b00) begin
         bad++; $display("FAIL dis_recfg got=%02b exp=00", {busy, err_ovf});
      end
   endtask

   task automatic test_async_reset();
      do_cfg(8'd8);
      src_vld = 1'b1; src_data = 16'h5A5A; act_in_req = 1'b1;
      tick();
      act_in_req = 1'b0;
      tick(); tick();
      total++; if (act_in_vld !== 1'b1) begin
         bad++; $display("FAIL arst_pre got=%b exp=1", act_in_vld);
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({src_rdy, act_in_vld, batch_done, busy, err_ovf} !== 5'b0 || act_in !== 16'h0) begin
         bad++; $display("FAIL arst_now flags=%05b act_in=%h exp=00000/0000",
                         {src_rdy, act_in_vld, batch_done, busy, err_ovf}, act_in);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if ({src_rdy, act_in_vld, busy} !== 3'b000) begin
            bad++; $display("FAIL arst_after c%0d got=%03b exp=000", i, {src_rdy, act_in_vld, busy});
         end
      end
      src_vld = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_abort();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
